// File: rtl/pipelined_segment_adder.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_segment_adder
//  Description : Pipelined add/subtract unit. WIDTH-bit operands are split
//                into SEG-bit segments and each pipeline stage adds one
//                segment, with the carry registered between stages.
//                Valid/ready handshake on both sides, global stall.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1      rising-edge clock
//    rst_n      in   1      asynchronous active-low reset
//    in_valid   in   1      operand beat valid
//    in_ready   out  1      unit accepts a beat this cycle
//    a, b       in   WIDTH  operands (unsigned or two's complement)
//    cin        in   1      carry-in, add mode only
//    sub        in   1      0: a+b+cin   1: a-b (a + ~b + 1)
//    out_valid  out  1      result beat valid
//    out_ready  in   1      consumer accepts result
//    sum        out  WIDTH  result, modulo 2^WIDTH
//    cout       out  1      carry out of MSB (sub: 1 = no borrow)
//    ovf        out  1      signed overflow
// ============================================================================
module pipelined_segment_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int c_stages = WIDTH / SEG;

  logic                w_stall;
  logic                w_en;
  logic [WIDTH-1:0]    w_b_eff;
  logic                w_c0;
  logic [c_stages-1:0] r_valid;
  // Registered carry out of each stage; bit k feeds stage k+1, the top bit is cout.
  logic [c_stages-1:0] w_carry;

  // A stalled output freezes the whole pipe, so nothing can be accepted either.
  assign w_stall   = r_valid[c_stages-1] & ~out_ready;
  assign w_en      = ~w_stall;
  assign in_ready  = w_en;
  assign out_valid = r_valid[c_stages-1];

  assign w_b_eff = sub ? ~b : b;
  assign w_c0    = sub | cin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (w_en) begin
      r_valid[0] <= in_valid;
      for (int k = 1; k < c_stages; k++) begin
        r_valid[k] <= r_valid[k-1];
      end
    end
  end

  // Segment j: operands are skewed j registers forward, added in stage j,
  // and the result segment then rides along to the last stage.
  for (genvar j = 0; j < c_stages; j++) begin : g_seg
    localparam int c_sum_depth = c_stages - j;

    logic [SEG-1:0] w_a_op;
    logic [SEG-1:0] w_b_op;
    logic           w_cin;
    logic [SEG:0]   w_add;
    logic [SEG-1:0] r_sum [c_sum_depth];
    logic           r_carry;

    if (j == 0) begin : g_direct
      assign w_a_op = a[j*SEG +: SEG];
      assign w_b_op = w_b_eff[j*SEG +: SEG];
      assign w_cin  = w_c0;
    end else begin : g_skew
      logic [SEG-1:0] r_a_dly [j];
      logic [SEG-1:0] r_b_dly [j];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int d = 0; d < j; d++) begin
            r_a_dly[d] <= '0;
            r_b_dly[d] <= '0;
          end
        end else if (w_en) begin
          r_a_dly[0] <= a[j*SEG +: SEG];
          r_b_dly[0] <= w_b_eff[j*SEG +: SEG];
          for (int d = 1; d < j; d++) begin
            r_a_dly[d] <= r_a_dly[d-1];
            r_b_dly[d] <= r_b_dly[d-1];
          end
        end
      end

      assign w_a_op = r_a_dly[j-1];
      assign w_b_op = r_b_dly[j-1];
      assign w_cin  = w_carry[j-1];
    end

    assign w_add = {1'b0, w_a_op} + {1'b0, w_b_op} + {{SEG{1'b0}}, w_cin};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int d = 0; d < c_sum_depth; d++) begin
          r_sum[d] <= '0;
        end
        r_carry <= 1'b0;
      end else if (w_en) begin
        r_sum[0] <= w_add[SEG-1:0];
        r_carry  <= w_add[SEG];
        for (int d = 1; d < c_sum_depth; d++) begin
          r_sum[d] <= r_sum[d-1];
        end
      end
    end

    assign w_carry[j]        = r_carry;
    assign sum[j*SEG +: SEG] = r_sum[c_sum_depth-1];

    if (j == c_stages - 1) begin : g_ovf
      logic r_ovf;
      // Carry into the MSB is recovered as a^b^sum at that bit; overflow is
      // that carry differing from the carry out.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ovf <= 1'b0;
        end else if (w_en) begin
          r_ovf <= w_a_op[SEG-1] ^ w_b_op[SEG-1] ^ w_add[SEG-1] ^ w_add[SEG];
        end
      end
      assign ovf = r_ovf;
    end
  end

  assign cout = w_carry[c_stages-1];

endmodule
`default_nettype wire

// File: tb/tb_pipelined_segment_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_segment_adder
//  Description : Self-checking bench for pipelined_segment_adder. Three
//                instances (16/4, 32/8, 8/8) share one clock and reset;
//                a scoreboard queue per instance holds expected results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_segment_adder;

  typedef struct packed {
    logic [33:0] e;   // {ovf, cout, sum[31:0]}
    logic [31:0] t;   // cycle the beat was accepted
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic [2:0]  iv;
  logic [2:0]  ordy;
  logic [2:0]  cin_v;
  logic [2:0]  sub_v;
  logic [31:0] ia [3];
  logic [31:0] ib [3];
  wire  [2:0]  ir;
  wire  [2:0]  ov;
  wire  [2:0]  co;
  wire  [2:0]  of;
  wire  [15:0] sm16;
  wire  [31:0] sm32;
  wire  [7:0]  sm8;

  ent_t        q0[$];
  ent_t        q1[$];
  ent_t        q2[$];
  logic [33:0] held [3];
  logic [2:0]  held_v;
  logic [2:0]  acc;
  logic        lat_chk;
  int          cyc;
  int          checks;
  int          errors;
  int          sent;
  int          stalls;
  logic        started;

  pipelined_segment_adder #(.WIDTH(16), .SEG(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(ia[0][15:0]), .b(ib[0][15:0]), .cin(cin_v[0]), .sub(sub_v[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sm16), .cout(co[0]), .ovf(of[0])
  );

  pipelined_segment_adder #(.WIDTH(32), .SEG(8)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(ia[1]), .b(ib[1]), .cin(cin_v[1]), .sub(sub_v[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sm32), .cout(co[1]), .ovf(of[1])
  );

  pipelined_segment_adder #(.WIDTH(8), .SEG(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(ia[2][7:0]), .b(ib[2][7:0]), .cin(cin_v[2]), .sub(sub_v[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .sum(sm8), .cout(co[2]), .ovf(of[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic int wid(input int d);
    return (d == 0) ? 16 : (d == 1) ? 32 : 8;
  endfunction

  function automatic int stg(input int d);
    return (d == 2) ? 1 : 4;
  endfunction

  // Reference: {cout,sum} = a + b' + c0 ; ovf when both operands share a sign
  // that the result does not.
  function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic c, input logic s);
    logic [31:0] mask;
    logic [31:0] am;
    logic [31:0] bb;
    logic [32:0] full;
    logic        v;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    am   = a & mask;
    bb   = (s ? ~b : b) & mask;
    full = {1'b0, am} + {1'b0, bb} + {32'h0, (s ? 1'b1 : c)};
    v    = (am[w-1] == bb[w-1]) && (full[w-1] != am[w-1]);
    return {v, full[w], full[31:0] & mask};
  endfunction

  function automatic logic [31:0] pick(input int w);
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h1 << (w - 1);
      default: return $urandom;
    endcase
  endfunction

  function automatic int qsize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic push(input int d, input logic [33:0] e, input int t);
    ent_t x;
    x.e = e;
    x.t = t;
    case (d)
      0:       q0.push_back(x);
      1:       q1.push_back(x);
      default: q2.push_back(x);
    endcase
  endtask

  task automatic pop(input int d, output ent_t x);
    case (d)
      0:       x = q0.pop_front();
      1:       x = q1.pop_front();
      default: x = q2.pop_front();
    endcase
  endtask

  task automatic chk(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  // One clock cycle: sample at the falling edge, score handshakes, then
  // return just after the next rising edge so the caller can drive inputs.
  task automatic tick();
    logic [31:0] s;
    logic [33:0] o;
    ent_t        x;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      case (d)
        0:       s = {16'h0, sm16};
        1:       s = sm32;
        default: s = {24'h0, sm8};
      endcase
      o = {of[d], co[d], s};
      chk("in_ready", d, ir[d], !(ov[d] && !ordy[d]));
      if (held_v[d]) begin
        chk("hold_valid", d, ov[d], 1'b1);
        chk("hold_data", d, o, held[d]);
      end
      acc[d] = iv[d] && ir[d];
      if (acc[d]) push(d, model(wid(d), ia[d], ib[d], cin_v[d], sub_v[d]), cyc);
      if (ov[d] && ordy[d]) begin
        chk("spurious_out", d, qsize(d) != 0, 1'b1);
        if (qsize(d) != 0) begin
          pop(d, x);
          chk("result", d, o, x.e);
          if (lat_chk) chk("latency", d, cyc - x.t, stg(d));
        end
      end
      held_v[d] = ov[d] && !ordy[d];
      held[d]   = o;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic beat0(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s);
    iv[0]    = 1'b1;
    ia[0]    = {16'h0, a};
    ib[0]    = {16'h0, b};
    cin_v[0] = c;
    sub_v[0] = s;
    acc[0]   = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (acc[0]) break;
    end
    chk("accept", 0, acc[0], 1'b1);
  endtask

  task automatic drain();
    iv   = '0;
    ordy = '1;
    for (int n = 0; n < 100 && (q0.size() + q1.size() + q2.size()) != 0; n++) tick();
    chk("drain", 0, q0.size() + q1.size() + q2.size(), 0);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    lat_chk = 1'b0;
    held_v  = '0;
    acc     = '0;
    iv      = '0;
    ordy    = '1;
    cin_v   = '0;
    sub_v   = '0;
    for (int d = 0; d < 3; d++) begin
      ia[d]   = '0;
      ib[d]   = '0;
      held[d] = '0;
    end
    rst_n = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 0, ov[0], 1'b0);
    chk("rst_sum", 0, sm16, 16'h0);
    chk("rst_cout", 0, co[0], 1'b0);
    chk("rst_ovf", 0, of[0], 1'b0);
    chk("rst_in_ready", 0, ir[0], 1'b1);
    rst_n = 1'b1;

    // Add with carry rippling across segment boundaries, latency checked
    lat_chk = 1'b1;
    beat0(16'h00FF, 16'h0001, 1'b0, 1'b0);
    drain();

    // Subtract: signed overflow, then borrow (cin ignored in sub mode)
    beat0(16'h8000, 16'h0001, 1'b0, 1'b1);
    beat0(16'h0000, 16'h0001, 1'b1, 1'b1);
    drain();

    // Full carry chain, then positive add overflow
    beat0(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    beat0(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    drain();
    lat_chk = 1'b0;

    // Backpressure: 8 back-to-back beats, 5-cycle stall once output appears
    sent    = 0;
    stalls  = 0;
    started = 1'b0;
    for (int n = 0; n < 80 && sent < 8; n++) begin
      iv[0]    = 1'b1;
      ia[0]    = 32'h1357 * (sent + 1);
      ib[0]    = 32'h0F0F + sent;
      cin_v[0] = sent[0];
      sub_v[0] = sent[1];
      if (ov[0]) started = 1'b1;
      if (started && stalls < 5) begin
        ordy[0] = 1'b0;
        stalls++;
      end else begin
        ordy[0] = 1'b1;
      end
      tick();
      if (acc[0]) sent++;
    end
    iv[0] = 1'b0;
    chk("bp_sent", 0, sent, 8);
    chk("bp_stalls", 0, stalls, 5);
    drain();

    // Reset with beats in flight
    for (int k = 0; k < 5; k++) beat0(16'h1111 * k[15:0], 16'h0101, 1'b0, 1'b0);
    iv[0] = 1'b0;
    chk("pre_rst_valid", 0, ov[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 0, ov[0], 1'b0);
    chk("async_rst_sum", 0, sm16, 16'h0);
    chk("async_rst_cout", 0, co[0], 1'b0);
    chk("async_rst_ovf", 0, of[0], 1'b0);
    q0.delete();
    q1.delete();
    q2.delete();
    held_v = '0;
    acc    = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) tick();
    chk("post_rst_idle", 0, ov[0], 1'b0);
    beat0(16'hA5A5, 16'h5A5B, 1'b0, 1'b0);
    drain();

    // Random traffic on all three configurations
    for (int n = 0; n < 6000; n++) begin
      for (int d = 0; d < 3; d++) begin
        if (!iv[d] || acc[d]) begin
          iv[d]    = ($urandom_range(0, 2) != 0);
          ia[d]    = pick(wid(d));
          ib[d]    = pick(wid(d));
          cin_v[d] = 1'($urandom_range(0, 1));
          sub_v[d] = 1'($urandom_range(0, 1));
        end
        ordy[d] = ($urandom_range(0, 3) != 0);
      end
      tick();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
